ip_header_parser: RTL and testbench
===================================

# ip_header_parser

Receive-side IPv4 header extractor between the Ethernet frame parser and the FPGA-side IP consumer. It takes a decoded Ethernet header plus the byte stream that follows it. It collects and validates the IPv4 header, presents the header fields on the IP output header interface, then forwards exactly the IP payload bytes. Invalid or truncated packets are dropped and flagged with error pulses.

## Interface
- `CHECK_CHECKSUM`, default 1: when 1, a header checksum failure drops the packet; when 0, the checksum is ignored.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `s_eth_hdr_valid` in 1: Ethernet header presented.
- `s_eth_hdr_ready` out 1: Ethernet header accepted.
- `s_eth_dest_mac` in 48, `s_eth_src_mac` in 48, `s_eth_type` in 16: Ethernet header fields.
- `s_tdata` in 8, `s_tvalid` in 1, `s_tready` out 1, `s_tlast` in 1: frame bytes after the Ethernet header.
- `ip_hdr` modport `IP_OUTPUT_HEADER_IF.Output`: parsed header; `hdr_valid`/`hdr_ready` handshake.
- `m_tdata` out 8, `m_tvalid` out 1, `m_tready` in 1, `m_tlast` out 1: IP payload stream.
- `m_tuser` out 1: qualifies `m_tlast`; 1 = payload truncated.
- `err_early_term` out 1: one-cycle pulse when `s_tlast` arrives inside the IP header.
- `err_invalid_hdr` out 1: one-cycle pulse on bad version, IHL, checksum, length or EtherType.

## Operation
- **States:** IDLE, HDR, HDR_OUT, PAYLOAD, DROP.
- **IDLE**
  - `s_eth_hdr_ready`=1, `s_tready`=0.
  - On the handshake: latch the Ethernet fields, clear the byte counter and checksum accumulator, go to HDR.
- **HDR**
  - `s_tready`=1; each accepted byte is stored at its field offset (bytes 0–19, big-endian).
  - Checksum: 16-bit words are accumulated in a 17-bit ones-complement sum, folding the end-around carry each word.
  - Options (IHL>5) are summed but not stored.
  - After byte 0: version≠4 or IHL<5 → `err_invalid_hdr`, go to DROP.
  - After byte 4·IHL−1, the packet is invalid if any of these holds:
    - the folded sum ≠ 16'hFFFF and `CHECK_CHECKSUM`=1;
    - total length < 4·IHL;
    - `s_eth_type`≠16'h0800.
  - Invalid → `err_invalid_hdr`, go to DROP (or IDLE if that byte had `s_tlast`). Valid → HDR_OUT.
  - `s_tlast` on any header byte before the last → `err_early_term`, go to IDLE.
  - `s_tlast` on the last header byte is treated as truncation, not early termination:
    - go to HDR_OUT with zero payload bytes received;
    - if the payload remaining is 0, the packet completes normally;
    - otherwise, at PAYLOAD entry, emit a single truncation beat: `m_tvalid`=1, `m_tlast`=1, `m_tuser`=1, `m_tdata`=0; return to IDLE when it is taken.
- **HDR_OUT**
  - `hdr_valid`=1 with all fields stable until `hdr_ready`.
  - Payload remaining = length − 4·IHL (16-bit, no wrap possible after the check).
  - Remaining 0 → IDLE; otherwise → PAYLOAD.
- **PAYLOAD**
  - Pass-through: `m_tdata`=`s_tdata`, `m_tvalid`=`s_tvalid`, `s_tready`=`m_tready`.
  - The counter decrements per transfer.
  - Count reaches 1 on a transfer: `m_tlast`=1, `m_tuser`=0.
    - If `s_tlast` is also set → IDLE.
    - Otherwise → DROP, discarding Ethernet padding.
  - `s_tlast` with count>1: `m_tlast`=1, `m_tuser`=1, go to IDLE.
- **DROP:** `s_tready`=1, discard bytes until `s_tlast`, then IDLE.
- **Pulses:** `err_*` pulses occur in the cycle after the offending byte.

## Timing
- **Reset values:**
  - State IDLE; `s_eth_hdr_ready`=0 during reset, 1 the cycle after.
  - `s_tready`, `hdr_valid`, `m_tvalid`, `m_tlast`, `m_tuser` = 0; `err_*` = 0.
  - Header field registers = 0.
- **Reset mid-operation:**
  - The packet is abandoned with no `m_tlast`.
  - `hdr_valid` deasserts in the same edge.
- **Latency:**
  - `hdr_valid` rises the cycle after the last header byte is accepted.
  - The first payload byte can transfer in the cycle after the `hdr_valid`/`hdr_ready` handshake.
  - Payload path: 0-cycle combinational.
- **Throughput:** 1 byte/cycle in HDR, PAYLOAD and DROP.
- **Handshake rules:**
  - No new Ethernet header is accepted until return to IDLE.
  - Bytes are never accepted while in HDR_OUT.

## Structure
- **Package `ip_pkg`:**
  - state enum `ip_rx_state_t`;
  - constants `ETH_TYPE_IPV4`=16'h0800, `IPV4_VERSION`=4, `IPV4_MIN_IHL`=5.
- **Sub-module `ip_checksum_accum`:** byte-wise ones-complement accumulator with clear/enable, exposing the folded sum. It is reusable by the IP transmit path.

## Test plan
- **Valid header, 95-byte payload:** header 45 00 00 73 00 00 40 00 40 11 B8 61 C0 A8 00 01 C0 A8 00 C7 followed by 95 payload bytes.
  - `hdr_valid` with length=0x0073, protocol=0x11, `source_ip`=C0A80001, `dest_ip`=C0A800C7.
  - 95 payload bytes out; `m_tlast` on the 95th; `m_tuser`=0.
- **Bad checksum, `CHECK_CHECKSUM`=1:** same header with byte 11 = 0x62 → `err_invalid_hdr` pulse, no `hdr_valid`, frame drained to `s_tlast`.
- **Truncated header:** `s_tlast` on header byte 10 → `err_early_term` pulse, return to IDLE, next frame parses normally.
- **Padding:** length=0x002E (26-byte payload) in a frame carrying 30 bytes after the header → `m_tlast` on payload byte 26, 4 padding bytes dropped.
- **Short payload:** length=0x0073 but `s_tlast` after 50 payload bytes → `m_tlast`=1 and `m_tuser`=1 on byte 50.
- **Backpressure and options:**
  - Hold `hdr_ready`=0 for 5 cycles → header fields stable, no input bytes consumed.
  - IHL=6 with a valid checksum → 4 option bytes skipped, payload = length−24.

Source files
------------

// File: rtl/ip_pkg.sv
// rtl/ip_pkg.sv - shared types and constants for the IPv4 receive path
package ip_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    HDR_OUT,
    PAYLOAD,
    DROP
  } ip_rx_state_t;

  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [3:0]  IPV4_VERSION  = 4'd4;
  localparam logic [3:0]  IPV4_MIN_IHL  = 4'd5;

  // IHL counts 32-bit words; the header length in bytes
  function automatic logic [15:0] ihl_bytes(input logic [3:0] ihl);
    return {10'd0, ihl, 2'b00};
  endfunction

endpackage

// File: rtl/IP_OUTPUT_HEADER_IF.sv
// rtl/IP_OUTPUT_HEADER_IF.sv - parsed IPv4 header with valid/ready handshake
interface IP_OUTPUT_HEADER_IF;
  logic        hdr_valid;
  logic        hdr_ready;
  logic [47:0] eth_dest_mac;
  logic [47:0] eth_src_mac;
  logic [15:0] eth_type;
  logic [3:0]  version;
  logic [3:0]  ihl;
  logic [5:0]  dscp;
  logic [1:0]  ecn;
  logic [15:0] length;
  logic [15:0] identification;
  logic [2:0]  flags;
  logic [12:0] fragment_offset;
  logic [7:0]  ttl;
  logic [7:0]  protocol;
  logic [15:0] header_checksum;
  logic [31:0] source_ip;
  logic [31:0] dest_ip;

  modport Output (
    output hdr_valid, eth_dest_mac, eth_src_mac, eth_type, version, ihl, dscp, ecn,
           length, identification, flags, fragment_offset, ttl, protocol,
           header_checksum, source_ip, dest_ip,
    input  hdr_ready
  );

  modport Input (
    input  hdr_valid, eth_dest_mac, eth_src_mac, eth_type, version, ihl, dscp, ecn,
           length, identification, flags, fragment_offset, ttl, protocol,
           header_checksum, source_ip, dest_ip,
    output hdr_ready
  );

  modport master (
    output hdr_valid, eth_dest_mac, eth_src_mac, eth_type, version, ihl, dscp, ecn,
           length, identification, flags, fragment_offset, ttl, protocol,
           header_checksum, source_ip, dest_ip,
    input  hdr_ready
  );

  modport slave (
    input  hdr_valid, eth_dest_mac, eth_src_mac, eth_type, version, ihl, dscp, ecn,
           length, identification, flags, fragment_offset, ttl, protocol,
           header_checksum, source_ip, dest_ip,
    output hdr_ready
  );

endinterface

// File: rtl/ip_checksum_accum.sv
// rtl/ip_checksum_accum.sv - byte-wise ones-complement 16-bit checksum accumulator
module ip_checksum_accum (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  input  logic [7:0]  data,
  output logic [15:0] sum
);

  logic [15:0] acc;
  logic [7:0]  hi_byte;
  logic        odd;
  logic [16:0] raw;
  logic [15:0] folded;

  // sum includes the current byte when it completes a word, so callers can
  // judge the header on the same cycle its final byte is accepted
  always_comb begin
    raw    = {1'b0, acc} + {1'b0, hi_byte, data};
    folded = raw[15:0] + {15'd0, raw[16]};
    sum    = (enable && odd) ? folded : acc;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc     <= 16'd0;
      hi_byte <= 8'd0;
      odd     <= 1'b0;
    end else if (enable) begin
      if (odd) acc <= folded;
      else     hi_byte <= data;
      odd <= ~odd;
    end
  end

endmodule

// File: rtl/ip_header_parser.sv
// rtl/ip_header_parser.sv - IPv4 header extractor and payload forwarder
module ip_header_parser
  import ip_pkg::*;
#(
  parameter bit CHECK_CHECKSUM = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_eth_hdr_valid,
  output logic        s_eth_hdr_ready,
  input  logic [47:0] s_eth_dest_mac,
  input  logic [47:0] s_eth_src_mac,
  input  logic [15:0] s_eth_type,
  input  logic [7:0]  s_tdata,
  input  logic        s_tvalid,
  output logic        s_tready,
  input  logic        s_tlast,
  IP_OUTPUT_HEADER_IF.Output ip_hdr,
  output logic [7:0]  m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic        m_tuser,
  output logic        err_early_term,
  output logic        err_invalid_hdr
);

  ip_rx_state_t      state;
  logic [5:0]        byte_cnt;
  logic [19:0][7:0]  hdr_b;
  logic [47:0]       eth_dest;
  logic [47:0]       eth_src;
  logic [15:0]       eth_type;
  logic [15:0]       remaining;
  logic              trunc;
  logic              hdr_valid_r;
  logic              err_early_r;
  logic              err_inv_r;

  logic [15:0] ck_sum;
  logic [15:0] hdr_len;
  logic [15:0] total_len;
  logic [5:0]  last_idx;
  logic        s_xfer;
  logic        hdr_bad;
  logic        in_pay;
  logic        pay_end;

  assign s_xfer    = s_tvalid && s_tready;
  assign hdr_len   = ihl_bytes(hdr_b[0][3:0]);
  assign last_idx  = hdr_len[5:0] - 6'd1;
  assign total_len = {hdr_b[2], hdr_b[3]};
  assign hdr_bad   = (CHECK_CHECKSUM && (ck_sum != 16'hFFFF)) ||
                     (total_len < hdr_len) || (eth_type != ETH_TYPE_IPV4);

  ip_checksum_accum u_cksum (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == IDLE),
    .enable ((state == HDR) && s_xfer),
    .data   (s_tdata),
    .sum    (ck_sum)
  );

  // Payload path is a combinational pass-through; reset masks it so an
  // abandoned packet never shows m_tlast
  assign in_pay          = (state == PAYLOAD) && !reset;
  assign pay_end         = s_tlast || (remaining == 16'd1);
  assign s_eth_hdr_ready = (state == IDLE) && !reset;
  assign s_tready        = !reset && ((state == HDR) || (state == DROP) ||
                                      ((state == PAYLOAD) && !trunc && m_tready));
  assign m_tvalid        = in_pay && (trunc || s_tvalid);
  assign m_tdata         = (in_pay && !trunc) ? s_tdata : 8'h00;
  assign m_tlast         = in_pay && (trunc || (s_tvalid && pay_end));
  assign m_tuser         = in_pay && (trunc || (s_tvalid && s_tlast && (remaining != 16'd1)));
  assign err_early_term  = err_early_r;
  assign err_invalid_hdr = err_inv_r;

  assign ip_hdr.hdr_valid       = hdr_valid_r;
  assign ip_hdr.eth_dest_mac    = eth_dest;
  assign ip_hdr.eth_src_mac     = eth_src;
  assign ip_hdr.eth_type        = eth_type;
  assign ip_hdr.version         = hdr_b[0][7:4];
  assign ip_hdr.ihl             = hdr_b[0][3:0];
  assign ip_hdr.dscp            = hdr_b[1][7:2];
  assign ip_hdr.ecn             = hdr_b[1][1:0];
  assign ip_hdr.length          = total_len;
  assign ip_hdr.identification  = {hdr_b[4], hdr_b[5]};
  assign ip_hdr.flags           = hdr_b[6][7:5];
  assign ip_hdr.fragment_offset = {hdr_b[6][4:0], hdr_b[7]};
  assign ip_hdr.ttl             = hdr_b[8];
  assign ip_hdr.protocol        = hdr_b[9];
  assign ip_hdr.header_checksum = {hdr_b[10], hdr_b[11]};
  assign ip_hdr.source_ip       = {hdr_b[12], hdr_b[13], hdr_b[14], hdr_b[15]};
  assign ip_hdr.dest_ip         = {hdr_b[16], hdr_b[17], hdr_b[18], hdr_b[19]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      byte_cnt    <= 6'd0;
      hdr_b       <= '0;
      eth_dest    <= 48'd0;
      eth_src     <= 48'd0;
      eth_type    <= 16'd0;
      remaining   <= 16'd0;
      trunc       <= 1'b0;
      hdr_valid_r <= 1'b0;
      err_early_r <= 1'b0;
      err_inv_r   <= 1'b0;
    end else begin
      err_early_r <= 1'b0;
      err_inv_r   <= 1'b0;
      case (state)
        IDLE: begin
          if (s_eth_hdr_valid) begin
            eth_dest <= s_eth_dest_mac;
            eth_src  <= s_eth_src_mac;
            eth_type <= s_eth_type;
            byte_cnt <= 6'd0;
            trunc    <= 1'b0;
            state    <= HDR;
          end
        end
        HDR: begin
          if (s_xfer) begin
            if (byte_cnt < 6'd20) hdr_b[byte_cnt[4:0]] <= s_tdata;
            byte_cnt <= byte_cnt + 6'd1;
            if (byte_cnt == 6'd0) begin
              if ((s_tdata[7:4] != IPV4_VERSION) || (s_tdata[3:0] < IPV4_MIN_IHL)) begin
                err_inv_r <= 1'b1;
                state     <= s_tlast ? IDLE : DROP;
              end else if (s_tlast) begin
                err_early_r <= 1'b1;
                state       <= IDLE;
              end
            end else if (byte_cnt == last_idx) begin
              if (hdr_bad) begin
                err_inv_r <= 1'b1;
                state     <= s_tlast ? IDLE : DROP;
              end else begin
                // tlast here means the frame ended right after the header
                hdr_valid_r <= 1'b1;
                trunc       <= s_tlast;
                state       <= HDR_OUT;
              end
            end else if (s_tlast) begin
              err_early_r <= 1'b1;
              state       <= IDLE;
            end
          end
        end
        HDR_OUT: begin
          if (ip_hdr.hdr_ready) begin
            hdr_valid_r <= 1'b0;
            remaining   <= total_len - hdr_len;
            state       <= (total_len == hdr_len) ? IDLE : PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (trunc) begin
            if (m_tready) state <= IDLE;
          end else if (s_tvalid && m_tready) begin
            remaining <= remaining - 16'd1;
            // reaching the IP length before tlast leaves Ethernet padding to drain
            if (pay_end) state <= ((remaining == 16'd1) && !s_tlast) ? DROP : IDLE;
          end
        end
        DROP: begin
          if (s_tvalid && s_tlast) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ip_header_parser.sv
// tb/tb_ip_header_parser.sv - table-driven bench for ip_header_parser
module tb_ip_header_parser;

  logic        clk;
  logic        reset;
  logic        s_eth_hdr_valid;
  logic        s_eth_hdr_ready;
  logic [47:0] s_eth_dest_mac;
  logic [47:0] s_eth_src_mac;
  logic [15:0] s_eth_type;
  logic [7:0]  s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic        m_tuser;
  logic        err_early_term;
  logic        err_invalid_hdr;

  IP_OUTPUT_HEADER_IF ip_hdr ();

  ip_header_parser #(.CHECK_CHECKSUM(1'b1)) dut (
    .clk             (clk),
    .reset           (reset),
    .s_eth_hdr_valid (s_eth_hdr_valid),
    .s_eth_hdr_ready (s_eth_hdr_ready),
    .s_eth_dest_mac  (s_eth_dest_mac),
    .s_eth_src_mac   (s_eth_src_mac),
    .s_eth_type      (s_eth_type),
    .s_tdata         (s_tdata),
    .s_tvalid        (s_tvalid),
    .s_tready        (s_tready),
    .s_tlast         (s_tlast),
    .ip_hdr          (ip_hdr),
    .m_tdata         (m_tdata),
    .m_tvalid        (m_tvalid),
    .m_tready        (m_tready),
    .m_tlast         (m_tlast),
    .m_tuser         (m_tuser),
    .err_early_term  (err_early_term),
    .err_invalid_hdr (err_invalid_hdr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ver;
    logic [3:0]  ihl;
    logic [15:0] len;
    logic [15:0] etype;
    bit          bad_ck;
    int          n_hdr;
    int          n_pay;
    int          e_hdr;
    int          e_beats;
    int          e_last;
    bit          e_user;
    bit          e_trunc;
    int          e_inv;
    int          e_early;
  } vec_t;

  vec_t       vecs [13];
  logic [7:0] hb [24];
  int         n_cmp = 0;
  int         n_fail = 0;
  bit         cur_trunc = 1'b0;

  // monitor state, written only by the monitor process
  int          mon_beats = 0, mon_lasts = 0, mon_hdrs = 0, mon_inv = 0, mon_early = 0;
  int          mon_derr = 0, mon_pkt = 0;
  bit          mon_user = 1'b0;
  logic [15:0] cap_len = 16'd0;
  logic [7:0]  cap_proto = 8'd0;
  logic [31:0] cap_src = 32'd0, cap_dst = 32'd0;

  int b_beats, b_lasts, b_hdrs, b_inv, b_early, b_derr;

  always @(negedge clk) begin
    if (!reset) begin
      if (s_eth_hdr_valid && s_eth_hdr_ready) begin
        mon_pkt  = 0;
        mon_user = 1'b0;
      end
      if (m_tvalid && m_tready) begin
        if (m_tdata !== (cur_trunc ? 8'h00 : 8'(mon_pkt + 1))) mon_derr++;
        mon_pkt++;
        mon_beats++;
        if (m_tlast) begin
          mon_lasts++;
          mon_user = m_tuser;
        end
      end
      if (ip_hdr.hdr_valid && ip_hdr.hdr_ready) begin
        mon_hdrs++;
        cap_len   = ip_hdr.length;
        cap_proto = ip_hdr.protocol;
        cap_src   = ip_hdr.source_ip;
        cap_dst   = ip_hdr.dest_ip;
      end
      if (err_invalid_hdr) mon_inv++;
      if (err_early_term)  mon_early++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out waiting for handshake", name);
  endtask

  task automatic snap();
    b_beats = mon_beats; b_lasts = mon_lasts; b_hdrs = mon_hdrs;
    b_inv = mon_inv; b_early = mon_early; b_derr = mon_derr;
  endtask

  task automatic check_counts(input string tag, input int e_hdr, input int e_beats,
                              input int e_last, input bit e_user, input int e_inv,
                              input int e_early);
    check({tag, "_hdr"},   64'(mon_hdrs - b_hdrs),   64'(e_hdr));
    check({tag, "_beats"}, 64'(mon_beats - b_beats), 64'(e_beats));
    check({tag, "_last"},  64'(mon_lasts - b_lasts), 64'(e_last));
    check({tag, "_user"},  64'(mon_user),            64'(e_user));
    check({tag, "_inv"},   64'(mon_inv - b_inv),     64'(e_inv));
    check({tag, "_early"}, 64'(mon_early - b_early), 64'(e_early));
    check({tag, "_data"},  64'(mon_derr - b_derr),   64'd0);
  endtask

  task automatic build_hdr(input logic [3:0] ver, input logic [3:0] ihl,
                           input logic [15:0] len, input bit bad);
    int n;
    int s;
    logic [15:0] ck;
    hb[0]  = {ver, ihl};  hb[1]  = 8'h00; hb[2]  = len[15:8]; hb[3]  = len[7:0];
    hb[4]  = 8'h00;       hb[5]  = 8'h00; hb[6]  = 8'h40;     hb[7]  = 8'h00;
    hb[8]  = 8'h40;       hb[9]  = 8'h11; hb[10] = 8'h00;     hb[11] = 8'h00;
    hb[12] = 8'hC0;       hb[13] = 8'hA8; hb[14] = 8'h00;     hb[15] = 8'h01;
    hb[16] = 8'hC0;       hb[17] = 8'hA8; hb[18] = 8'h00;     hb[19] = 8'hC7;
    hb[20] = 8'h01;       hb[21] = 8'h02; hb[22] = 8'h03;     hb[23] = 8'h04;
    n = (ihl > 4'd5) ? 24 : 20;
    s = 0;
    for (int k = 0; k < n; k += 2) s = s + 32'({hb[k], hb[k+1]});
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    ck = ~s[15:0];
    if (bad) ck = ck + 16'd1;
    hb[10] = ck[15:8];
    hb[11] = ck[7:0];
  endtask

  task automatic send_eth(input logic [15:0] et);
    int n = 0;
    s_eth_dest_mac  = 48'h02_00_00_00_00_01;
    s_eth_src_mac   = 48'h02_00_00_00_00_02;
    s_eth_type      = et;
    s_eth_hdr_valid = 1'b1;
    @(negedge clk);
    while (!s_eth_hdr_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!s_eth_hdr_ready) timeout_fail("eth_hdr_wait");
    @(posedge clk);
    #1 s_eth_hdr_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit last);
    int n = 0;
    s_tdata  = d;
    s_tlast  = last;
    s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!s_tready) timeout_fail("byte_wait");
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic send_frame(input vec_t v);
    int total;
    total = v.n_hdr + v.n_pay;
    send_eth(v.etype);
    build_hdr(v.ver, v.ihl, v.len, v.bad_ck);
    for (int k = 0; k < v.n_hdr; k++) send_byte(hb[k], k == total - 1);
    for (int p = 0; p < v.n_pay; p++) send_byte(8'(p + 1), (v.n_hdr + p) == total - 1);
  endtask

  task automatic run_vec(input int i);
    cur_trunc = vecs[i].e_trunc;
    snap();
    send_frame(vecs[i]);
    repeat (6) @(posedge clk);
    #1;
    check_counts($sformatf("v%0d", i), vecs[i].e_hdr, vecs[i].e_beats, vecs[i].e_last,
                 vecs[i].e_user, vecs[i].e_inv, vecs[i].e_early);
    if (i == 0) begin
      check("v0_length", 64'(cap_len),   64'h0073);
      check("v0_proto",  64'(cap_proto), 64'h11);
      check("v0_src",    64'(cap_src),   64'hC0A80001);
      check("v0_dst",    64'(cap_dst),   64'hC0A800C7);
    end
  endtask

  initial begin
    //                ver   ihl   len       etype     bad  nh  np  hdr beats last user trn inv early
    vecs[0]  = '{4'd4, 4'd5, 16'h0073, 16'h0800, 0, 20, 95, 1, 95, 1, 0, 0, 0, 0};
    vecs[1]  = '{4'd4, 4'd5, 16'h0073, 16'h0800, 1, 20, 95, 0, 0,  0, 0, 0, 1, 0};
    vecs[2]  = '{4'd4, 4'd5, 16'h0073, 16'h0800, 0, 11, 0,  0, 0,  0, 0, 0, 0, 1};
    vecs[3]  = '{4'd4, 4'd5, 16'h001E, 16'h0800, 0, 20, 10, 1, 10, 1, 0, 0, 0, 0};
    vecs[4]  = '{4'd4, 4'd5, 16'h002E, 16'h0800, 0, 20, 30, 1, 26, 1, 0, 0, 0, 0};
    vecs[5]  = '{4'd4, 4'd5, 16'h0073, 16'h0800, 0, 20, 50, 1, 50, 1, 1, 0, 0, 0};
    vecs[6]  = '{4'd4, 4'd6, 16'h0030, 16'h0800, 0, 24, 24, 1, 24, 1, 0, 0, 0, 0};
    vecs[7]  = '{4'd6, 4'd5, 16'h001E, 16'h0800, 0, 20, 10, 0, 0,  0, 0, 0, 1, 0};
    vecs[8]  = '{4'd4, 4'd5, 16'h001E, 16'h86DD, 0, 20, 10, 0, 0,  0, 0, 0, 1, 0};
    vecs[9]  = '{4'd4, 4'd5, 16'h0010, 16'h0800, 0, 20, 10, 0, 0,  0, 0, 0, 1, 0};
    vecs[10] = '{4'd4, 4'd5, 16'h0073, 16'h0800, 0, 20, 0,  1, 1,  1, 1, 1, 0, 0};
    vecs[11] = '{4'd4, 4'd5, 16'h0014, 16'h0800, 0, 20, 0,  1, 0,  0, 0, 0, 0, 0};
    vecs[12] = '{4'd4, 4'd4, 16'h001E, 16'h0800, 0, 20, 10, 0, 0,  0, 0, 0, 1, 0};

    reset = 1'b1;
    s_eth_hdr_valid = 1'b0;
    s_eth_dest_mac = 48'd0;
    s_eth_src_mac = 48'd0;
    s_eth_type = 16'd0;
    s_tdata = 8'd0;
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    m_tready = 1'b1;
    ip_hdr.hdr_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_eth_ready", 64'(s_eth_hdr_ready),  64'd0);
    check("rst_s_tready",  64'(s_tready),         64'd0);
    check("rst_hdr_valid", 64'(ip_hdr.hdr_valid), 64'd0);
    check("rst_m_tvalid",  64'(m_tvalid),         64'd0);
    check("rst_m_tlast",   64'(m_tlast),          64'd0);
    check("rst_m_tuser",   64'(m_tuser),          64'd0);
    check("rst_errs",      64'({err_early_term, err_invalid_hdr}), 64'd0);
    check("rst_length",    64'(ip_hdr.length),    64'd0);
    check("rst_src_ip",    64'(ip_hdr.source_ip), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("post_rst_eth_ready", 64'(s_eth_hdr_ready), 64'd1);
    check("post_rst_s_tready",  64'(s_tready),        64'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) run_vec(i);

    // header backpressure: fields stable, no bytes taken while hdr_ready is low
    cur_trunc = 1'b0;
    snap();
    ip_hdr.hdr_ready = 1'b0;
    send_eth(16'h0800);
    build_hdr(4'd4, 4'd5, 16'h001E, 1'b0);
    for (int k = 0; k < 20; k++) send_byte(hb[k], 1'b0);
    s_tdata = 8'h01;
    s_tvalid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp%0d_hdr_valid", c), 64'(ip_hdr.hdr_valid), 64'd1);
      check($sformatf("bp%0d_s_tready", c),  64'(s_tready),         64'd0);
      check($sformatf("bp%0d_length", c),    64'(ip_hdr.length),    64'h001E);
      check($sformatf("bp%0d_src", c),       64'(ip_hdr.source_ip), 64'hC0A80001);
    end
    @(posedge clk);
    #1 ip_hdr.hdr_ready = 1'b1;
    for (int p = 0; p < 10; p++) send_byte(8'(p + 1), p == 9);
    repeat (4) @(posedge clk);
    #1;
    check_counts("bp", 1, 10, 1, 1'b0, 0, 0);

    // reset while the header is being presented
    ip_hdr.hdr_ready = 1'b0;
    send_eth(16'h0800);
    for (int k = 0; k < 20; k++) send_byte(hb[k], 1'b0);
    @(negedge clk);
    check("rm_hdr_valid_before", 64'(ip_hdr.hdr_valid), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rm_hdr_valid_after", 64'(ip_hdr.hdr_valid), 64'd0);
    reset = 1'b0;
    ip_hdr.hdr_ready = 1'b1;

    // reset mid-payload together with a tlast byte: no m_tlast may escape
    snap();
    send_eth(16'h0800);
    for (int k = 0; k < 20; k++) send_byte(hb[k], 1'b0);
    for (int p = 0; p < 3; p++) send_byte(8'(p + 1), 1'b0);
    s_tdata = 8'h04;
    s_tlast = 1'b1;
    s_tvalid = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    check("rm_m_tlast",  64'(m_tlast),  64'd0);
    check("rm_m_tvalid", 64'(m_tvalid), 64'd0);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("rm_eth_ready", 64'(s_eth_hdr_ready), 64'd1);
    check("rm_lasts",     64'(mon_lasts - b_lasts), 64'd0);
    check("rm_beats",     64'(mon_beats - b_beats), 64'd3);
    @(posedge clk);
    #1;

    run_vec(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
